// File: rtl/timer_pkg.sv
// Shared definitions for the TIM controller: FSM states, register map and
// CTRL/STATUS bit positions (mirrored in the core's software header).
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_PSC    = 8'h04;
  localparam logic [7:0] OFF_ARR    = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_CNT    = 8'h10;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_ONESHOT_BIT = 1;
  localparam int unsigned CTRL_IE_BIT      = 2;

  localparam int unsigned STAT_UIF_BIT     = 0;
  localparam int unsigned STAT_RUNNING_BIT = 1;
  localparam int unsigned STAT_ERR_BIT     = 2;

endpackage

// File: rtl/timer_ctrl_regfile.sv
// Register window of the TIM controller: bus decode, CTRL, shadow PSC/ARR,
// W1C STATUS bits, preload-pending flag and the registered read path.
module timer_ctrl_regfile
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rvalid,
  input  logic [CNT_W-1:0]  tim_cnt,
  input  logic              running_i,
  input  logic              set_uif_i,
  input  logic              set_err_i,
  input  logic              clr_en_i,
  input  logic              clr_pend_i,
  output logic              ctrl_wr_o,
  output logic              wr_en_o,
  output logic              oneshot_o,
  output logic              ie_o,
  output logic              uif_o,
  output logic [CNT_W-1:0]  psc_o,
  output logic [CNT_W-1:0]  arr_o,
  output logic              upd_pend_o
);

  logic              wr, rd;
  logic              ctrl_wr, psc_wr, arr_wr, status_wr;
  logic              en_q, en_d;
  logic              oneshot_q, oneshot_d;
  logic              ie_q, ie_d;
  logic              uif_q, uif_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  psc_q, psc_d;
  logic [CNT_W-1:0]  arr_q, arr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;
  logic              unused_wdata;

  assign wr        = bus_sel & bus_we;
  assign rd        = bus_sel & ~bus_we;
  assign ctrl_wr   = wr && (bus_addr == OFF_CTRL[ADDR_W-1:0]);
  assign psc_wr    = wr && (bus_addr == OFF_PSC[ADDR_W-1:0]);
  assign arr_wr    = wr && (bus_addr == OFF_ARR[ADDR_W-1:0]);
  assign status_wr = wr && (bus_addr == OFF_STATUS[ADDR_W-1:0]);

  assign unused_wdata = ^bus_wdata[DATA_W-1:CNT_W];

  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    ie_d      = ie_q;
    if (ctrl_wr) begin
      en_d      = bus_wdata[CTRL_EN_BIT];
      oneshot_d = bus_wdata[CTRL_ONESHOT_BIT];
      ie_d      = bus_wdata[CTRL_IE_BIT];
    end
    if (clr_en_i) en_d = 1'b0;

    // W1C first, hardware set last so a same-cycle event is never lost
    uif_d = uif_q;
    err_d = err_q;
    if (status_wr && bus_wdata[STAT_UIF_BIT]) uif_d = 1'b0;
    if (status_wr && bus_wdata[STAT_ERR_BIT]) err_d = 1'b0;
    if (set_uif_i) uif_d = 1'b1;
    if (set_err_i) err_d = 1'b1;

    psc_d = psc_wr ? bus_wdata[CNT_W-1:0] : psc_q;
    arr_d = arr_wr ? bus_wdata[CNT_W-1:0] : arr_q;

    // Clear happens on LOAD entry; a write landing on that same edge re-arms the flag
    pend_d = pend_q;
    if (clr_pend_i) pend_d = 1'b0;
    if ((psc_wr || arr_wr) && running_i) pend_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    case (bus_addr)
      OFF_CTRL[ADDR_W-1:0]: begin
        rdata_d[CTRL_EN_BIT]      = en_q;
        rdata_d[CTRL_ONESHOT_BIT] = oneshot_q;
        rdata_d[CTRL_IE_BIT]      = ie_q;
      end
      OFF_PSC[ADDR_W-1:0]:    rdata_d[CNT_W-1:0] = psc_q;
      OFF_ARR[ADDR_W-1:0]:    rdata_d[CNT_W-1:0] = arr_q;
      OFF_STATUS[ADDR_W-1:0]: begin
        rdata_d[STAT_UIF_BIT]     = uif_q;
        rdata_d[STAT_RUNNING_BIT] = running_i;
        rdata_d[STAT_ERR_BIT]     = err_q;
      end
      OFF_CNT[ADDR_W-1:0]:    rdata_d[CNT_W-1:0] = tim_cnt;
      default:                rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      ie_q      <= 1'b0;
      uif_q     <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      psc_q     <= '0;
      arr_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      ie_q      <= ie_d;
      uif_q     <= uif_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      psc_q     <= psc_d;
      arr_q     <= arr_d;
      rvalid_q  <= rd;
      if (rd) rdata_q <= rdata_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign ctrl_wr_o  = ctrl_wr;
  assign wr_en_o    = bus_wdata[CTRL_EN_BIT];
  assign oneshot_o  = oneshot_q;
  assign ie_o       = ie_q;
  assign uif_o      = uif_q;
  assign psc_o      = psc_q;
  assign arr_o      = arr_q;
  assign upd_pend_o = pend_q;

endmodule

// File: rtl/timer_ctrl.sv
// TIM controller top: IDLE/LOAD/RUN sequencing FSM, active PSC/ARR registers
// and the level update interrupt.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rvalid,
  output logic              tim_en,
  output logic              tim_load,
  output logic [CNT_W-1:0]  tim_psc,
  output logic [CNT_W-1:0]  tim_arr,
  input  logic [CNT_W-1:0]  tim_cnt,
  input  logic              tim_done,
  output logic              irq
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] act_psc_q, act_psc_d;
  logic [CNT_W-1:0] act_arr_q, act_arr_d;

  logic             ctrl_wr, wr_en, oneshot, ie, uif, upd_pend;
  logic [CNT_W-1:0] sh_psc, sh_arr;
  logic             running, set_uif, set_err, clr_en, load_entry;

  timer_ctrl_regfile #(
    .CNT_W  (CNT_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .bus_sel    (bus_sel),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .tim_cnt    (tim_cnt),
    .running_i  (running),
    .set_uif_i  (set_uif),
    .set_err_i  (set_err),
    .clr_en_i   (clr_en),
    .clr_pend_i (load_entry),
    .ctrl_wr_o  (ctrl_wr),
    .wr_en_o    (wr_en),
    .oneshot_o  (oneshot),
    .ie_o       (ie),
    .uif_o      (uif),
    .psc_o      (sh_psc),
    .arr_o      (sh_arr),
    .upd_pend_o (upd_pend)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      act_psc_q <= '0;
      act_arr_q <= '0;
    end else begin
      state_q   <= state_d;
      act_psc_q <= act_psc_d;
      act_arr_q <= act_arr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ctrl_wr && wr_en) state_d = ST_LOAD;
      ST_LOAD: state_d = (act_arr_q == '0) ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (tim_done) begin
          if (oneshot)       state_d = ST_IDLE;
          else if (upd_pend) state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ctrl_wr && !wr_en) state_d = ST_IDLE;
  end

  // Shadow is copied on the edge into LOAD so tim_psc/tim_arr already hold
  // the new values while tim_load is high; the zero-ARR check uses that copy.
  assign load_entry = (state_d == ST_LOAD);

  always_comb begin
    act_psc_d = act_psc_q;
    act_arr_d = act_arr_q;
    if (load_entry) begin
      act_psc_d = sh_psc;
      act_arr_d = sh_arr;
    end
  end

  always_comb begin
    tim_en   = 1'b0;
    tim_load = 1'b0;
    running  = 1'b0;
    set_uif  = 1'b0;
    set_err  = 1'b0;
    clr_en   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        tim_load = (act_arr_q != '0);
        set_err  = (act_arr_q == '0);
        clr_en   = (act_arr_q == '0);
      end
      ST_RUN: begin
        tim_en  = 1'b1;
        running = 1'b1;
        set_uif = tim_done;
        clr_en  = tim_done && oneshot;
      end
      default: ;
    endcase
  end

  assign tim_psc = act_psc_q;
  assign tim_arr = act_arr_q;
  assign irq     = uif & ie;

endmodule
